memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage; consumes its ALU result, store data, destination register and control bits.
- Contains the EX/MEM register, a word-addressed data memory with configurable access latency, and the MEM/WB register feeding write-back.
- Raises a stall to freeze upstream stages while a multi-cycle load or store completes.

Parameters:
- DEPTH, 256, data memory depth in 32-bit words (power of 2).
- LAT, 2, memory access latency in cycles (>=1).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- regWriteE  in  1  register write enable from EX.
- memToRegE  in  1  load indicator from EX (write-back takes memory data).
- memWriteE  in  1  store indicator from EX.
- AluOutE  in  32  ALU result; byte address for loads/stores.
- WriteDataE  in  32  store data.
- writeRegE  in  5  destination register.
- stallM  out  1  high while a memory op is in progress; upstream must hold.
- regWriteM  out  1  EX/MEM register copy, for the forwarding unit.
- writeRegM  out  5  EX/MEM register copy, for the forwarding unit.
- AluOutM  out  32  EX/MEM register copy, for the forwarding unit.
- regWriteW  out  1  MEM/WB register write enable.
- memToRegW  out  1  MEM/WB load select.
- ReadDataW  out  32  loaded word.
- AluOutW  out  32  ALU result forwarded to WB.
- writeRegW  out  5  destination register to WB.

Behaviour:
- Reset: all M and W registers, counter and memory-control state go to 0; stallM=0. Memory contents are not cleared.
- FSM states:
  - IDLE: cnt==0.
  - WAIT: cnt!=0.
  - stallM = (state==WAIT), combinational from cnt.
- EX/MEM capture: on posedge when !stallM, latch all E inputs into M registers.
  - On capture, load cnt = LAT-1 if (memToRegE|memWriteE), else 0.
  - While stallM=1, M registers hold and cnt decrements by 1 each cycle.
- Address: word index = AluOutM[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- Store commit: mem[idx] <= WriteDataM on the single posedge where cnt==0 and memWriteM=1. Exactly one write per store, never during WAIT.
- Load: asynchronous array read at idx. On the cnt==0 posedge it is registered into ReadDataW.
- MEM/WB capture: on posedge with cnt==0, copy regWriteM, memToRegM, AluOutM, writeRegM into W; ReadDataW gets the memory word.
  - In WAIT, W receives a bubble: regWriteW=0, memToRegW=0, other W fields hold.
- Latency: a non-memory op reaches W 1 cycle after entering M. A memory op reaches W LAT cycles after entering M, with stallM high for LAT-1 cycles.
- Back-to-back memory ops: the second is captured the same posedge the first leaves M; no extra bubble.
- Store followed by load to the same address: the load sees the new data, because the store commits before the load occupies M.
- LAT=1: stallM is never asserted.
- Reset asserted mid-WAIT: a pending store is dropped (no write), the counter clears, and outputs go to reset values the next cycle.
- memWriteE and memToRegE both high: treated as a store; memToRegW is still propagated.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalignW (1 bit), registered with W.
  - misalignW is set when a load or store in M has AluOutM[1:0]!=0.
  - A misaligned store is suppressed (no memory write).
  - A misaligned load forces regWriteW=0.
  - Latency is unchanged.
- Undefined: no misalignW port; AluOutM[1:0] is ignored and access is to the truncated word address.

Decomposition:
- Shared pipeline package holds:
  - the M-stage and W-stage control bundle typedefs (regWrite, memToReg, memWrite);
  - constants REG_ADDR_W=5 and DATA_W=32;
  - FSM state encodings IDLE/WAIT.
- One sub-module, data_memory: DEPTH-word array, async read, sync write with enable.
- The stage instantiates data_memory and contains the pipeline registers plus the latency counter.

Test Plan:
- Reset with reset=1 for 2 cycles, then release -> every W output is 0, stallM=0, regWriteM=0.
- Non-memory op AluOutE=0x1234, writeRegE=5, regWriteE=1 -> AluOutW=0x1234, writeRegW=5, regWriteW=1 one cycle after the M capture; stallM stays 0.
- Store 0xDEADBEEF to 0x10, then load from 0x10, LAT=2 -> stallM high 1 cycle for each op; ReadDataW=0xDEADBEEF, memToRegW=1; bubble (regWriteW=0) during each stall.
- LAT=3, load issued while upstream keeps presenting a new op -> stallM high 2 cycles, E inputs during the stall are not captured, next op is captured on the third edge.
- Assert reset while a store to 0x20 is in WAIT -> a later load from 0x20 returns the old value, confirming no write occurred.
- With MEM_ALIGN_CHECK_EN, store to 0x22 -> misalignW=1, memory word at 0x20 unchanged; a load to 0x21 gives regWriteW=0.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: control bundles,
// datapath widths and the memory-wait FSM state encoding.
package memory_access_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Control bits carried through the EX/MEM register.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ctrl_m_t;

  // Control bits carried through the MEM/WB register.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } ctrl_w_t;

  // IDLE: no access outstanding; WAIT: latency counter still running.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/memory_access_stage_data_memory.sv
// Word-addressed data memory: asynchronous read, synchronous write with
// enable. Contents are never reset.
module data_memory
  import memory_access_stage_pkg::*;
#(
  parameter int  DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single-port write; read shares the same address and sees old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, data memory
// with LAT-cycle access latency, and MEM/WB register. A load or store
// holds M for LAT-1 extra cycles, signalled upstream via stallM.
// Optional build macro MEM_ALIGN_CHECK_EN adds misalignW, suppresses
// misaligned stores and squashes the register write of misaligned loads.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regWriteE,
  input  logic                  memToRegE,
  input  logic                  memWriteE,
  input  logic [DATA_W-1:0]     AluOutE,
  input  logic [DATA_W-1:0]     WriteDataE,
  input  logic [REG_ADDR_W-1:0] writeRegE,
  output logic                  stallM,
  output logic                  regWriteM,
  output logic [REG_ADDR_W-1:0] writeRegM,
  output logic [DATA_W-1:0]     AluOutM,
  output logic                  regWriteW,
  output logic                  memToRegW,
  output logic [DATA_W-1:0]     ReadDataW,
  output logic [DATA_W-1:0]     AluOutW,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  misalignW,
`endif
  output logic [REG_ADDR_W-1:0] writeRegW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  ctrl_m_t                 ctrl_m_q, ctrl_m_d;
  logic [DATA_W-1:0]       alu_m_q, alu_m_d;
  logic [DATA_W-1:0]       wdata_m_q, wdata_m_d;
  logic [REG_ADDR_W-1:0]   wreg_m_q, wreg_m_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  ctrl_w_t                 ctrl_w_q, ctrl_w_d;
  logic [DATA_W-1:0]       alu_w_q, alu_w_d;
  logic [DATA_W-1:0]       rdata_w_q, rdata_w_d;
  logic [REG_ADDR_W-1:0]   wreg_w_q, wreg_w_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic                    mis_w_q, mis_w_d;
`endif

  state_e                  state;
  logic                    misaligned;
  logic                    mem_we;
  logic [AW-1:0]           mem_idx;
  logic [DATA_W-1:0]       mem_rdata;

  // The latency counter is the FSM state: any residual count means WAIT.
  assign state = (cnt_q == '0) ? IDLE : WAIT;

  // Byte-address bits below the word and above the array depth are dropped.
  assign mem_idx = alu_m_q[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (ctrl_m_q.mem_to_reg | ctrl_m_q.mem_write) &
                      (alu_m_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A store commits once, on the edge it leaves M; reset drops it.
  assign mem_we = (state == IDLE) & ctrl_m_q.mem_write & ~misaligned & ~reset;

  data_memory #(
    .DEPTH (DEPTH)
  ) u_data_memory (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (wdata_m_q),
    .rdata (mem_rdata)
  );

  // Next-state: in IDLE advance both pipeline registers; in WAIT hold M,
  // count down and send a bubble into W.
  always_comb begin
    ctrl_m_d  = ctrl_m_q;
    alu_m_d   = alu_m_q;
    wdata_m_d = wdata_m_q;
    wreg_m_d  = wreg_m_q;
    cnt_d     = cnt_q;
    ctrl_w_d  = ctrl_w_q;
    alu_w_d   = alu_w_q;
    rdata_w_d = rdata_w_q;
    wreg_w_d  = wreg_w_q;
`ifdef MEM_ALIGN_CHECK_EN
    mis_w_d   = mis_w_q;
`endif
    if (state == IDLE) begin
      ctrl_m_d  = '{reg_write: regWriteE, mem_to_reg: memToRegE, mem_write: memWriteE};
      alu_m_d   = AluOutE;
      wdata_m_d = WriteDataE;
      wreg_m_d  = writeRegE;
      cnt_d     = (memToRegE | memWriteE) ? CNT_LOAD : '0;
      ctrl_w_d.reg_write  = ctrl_m_q.reg_write & ~(misaligned & ctrl_m_q.mem_to_reg);
      ctrl_w_d.mem_to_reg = ctrl_m_q.mem_to_reg;
      alu_w_d   = alu_m_q;
      rdata_w_d = mem_rdata;
      wreg_w_d  = wreg_m_q;
`ifdef MEM_ALIGN_CHECK_EN
      mis_w_d   = misaligned;
`endif
    end else begin
      cnt_d    = cnt_q - 1'b1;
      ctrl_w_d = '0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_w_d  = 1'b0;
`endif
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_m_q  <= '0;
      alu_m_q   <= '0;
      wdata_m_q <= '0;
      wreg_m_q  <= '0;
      cnt_q     <= '0;
      ctrl_w_q  <= '0;
      alu_w_q   <= '0;
      rdata_w_q <= '0;
      wreg_w_q  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_w_q   <= 1'b0;
`endif
    end else begin
      ctrl_m_q  <= ctrl_m_d;
      alu_m_q   <= alu_m_d;
      wdata_m_q <= wdata_m_d;
      wreg_m_q  <= wreg_m_d;
      cnt_q     <= cnt_d;
      ctrl_w_q  <= ctrl_w_d;
      alu_w_q   <= alu_w_d;
      rdata_w_q <= rdata_w_d;
      wreg_w_q  <= wreg_w_d;
`ifdef MEM_ALIGN_CHECK_EN
      mis_w_q   <= mis_w_d;
`endif
    end
  end

  assign stallM    = (state == WAIT);
  assign regWriteM = ctrl_m_q.reg_write;
  assign writeRegM = wreg_m_q;
  assign AluOutM   = alu_m_q;
  assign regWriteW = ctrl_w_q.reg_write;
  assign memToRegW = ctrl_w_q.mem_to_reg;
  assign ReadDataW = rdata_w_q;
  assign AluOutW   = alu_w_q;
  assign writeRegW = wreg_w_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalignW = mis_w_q;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: three instances (LAT = 1, 2, 3) share one
// stimulus stream and are each checked every cycle against a schedule-level
// model (an op accepted on edge c retires on edge c+LAT for memory ops or
// c+1 otherwise; M accepts only when the previous op has retired).
// Honours MEM_ALIGN_CHECK_EN when defined.
module tb_memory_access_stage;

  localparam int N     = 3;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        e_rw = 1'b0, e_mtr = 1'b0, e_mw = 1'b0;
  logic [31:0] e_alu = '0, e_wd = '0;
  logic [4:0]  e_wr = '0;

  logic        o_stall [N];
  logic        o_rwm   [N];
  logic [4:0]  o_wrm   [N];
  logic [31:0] o_alum  [N];
  logic        o_rww   [N];
  logic        o_mtrw  [N];
  logic [31:0] o_rdw   [N];
  logic [31:0] o_aluw  [N];
  logic [4:0]  o_wrw   [N];
`ifdef MEM_ALIGN_CHECK_EN
  logic        o_mis   [N];
`endif

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      memory_access_stage #(
        .DEPTH (DEPTH),
        .LAT   (gi + 1)
      ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .regWriteE  (e_rw),
        .memToRegE  (e_mtr),
        .memWriteE  (e_mw),
        .AluOutE    (e_alu),
        .WriteDataE (e_wd),
        .writeRegE  (e_wr),
        .stallM     (o_stall[gi]),
        .regWriteM  (o_rwm[gi]),
        .writeRegM  (o_wrm[gi]),
        .AluOutM    (o_alum[gi]),
        .regWriteW  (o_rww[gi]),
        .memToRegW  (o_mtrw[gi]),
        .ReadDataW  (o_rdw[gi]),
        .AluOutW    (o_aluw[gi]),
`ifdef MEM_ALIGN_CHECK_EN
        .misalignW  (o_mis[gi]),
`endif
        .writeRegW  (o_wrw[gi])
      );
    end
  endgenerate

  // Model state: op currently in M (p_*), expected W (x_*), memory image.
  int          ecount = 0;
  logic        p_rw [N], p_mtr [N], p_mw [N];
  logic [31:0] p_alu [N], p_wd [N];
  logic [4:0]  p_wr [N];
  int          p_due [N], p_tag [N];
  logic        x_rw [N], x_mtr [N], x_mis [N];
  logic [31:0] x_alu [N], x_rd [N];
  logic [4:0]  x_wr [N];
  bit          x_rdk [N];
  logic [31:0] mm [N][DEPTH];
  bit          mk [N][DEPTH];
  bit          acc [N], retired [N];
  int          r_tag [N], st_cnt [N];
  int          cur_tag = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat=%0d t=%0t actual=%h expected=%h", name, inst + 1, $time, act, exp);
    end
  endtask

  task automatic model_step();
    ecount++;
    for (int i = 0; i < N; i++) begin
      logic [7:0] idx;
      bit mis;
      acc[i] = 1'b0;
      retired[i] = 1'b0;
      if (reset) begin
        x_rw[i] = 0; x_mtr[i] = 0; x_mis[i] = 0; x_alu[i] = '0; x_rd[i] = '0;
        x_wr[i] = '0; x_rdk[i] = 1'b1;
        p_rw[i] = 0; p_mtr[i] = 0; p_mw[i] = 0; p_alu[i] = '0; p_wd[i] = '0;
        p_wr[i] = '0; p_tag[i] = 0; p_due[i] = ecount + 1;
      end else if (p_due[i] == ecount) begin
        idx = p_alu[i][9:2];
`ifdef MEM_ALIGN_CHECK_EN
        mis = (p_mtr[i] || p_mw[i]) && (p_alu[i][1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        x_rw[i]  = p_rw[i] & ~(mis & p_mtr[i]);
        x_mtr[i] = p_mtr[i];
        x_alu[i] = p_alu[i];
        x_wr[i]  = p_wr[i];
        x_rd[i]  = mm[i][idx];
        x_rdk[i] = mk[i][idx];
        x_mis[i] = mis;
        if (p_mw[i] && !mis) begin
          mm[i][idx] = p_wd[i];
          mk[i][idx] = 1'b1;
        end
        retired[i] = 1'b1;
        r_tag[i]   = p_tag[i];
        p_rw[i] = e_rw; p_mtr[i] = e_mtr; p_mw[i] = e_mw;
        p_alu[i] = e_alu; p_wd[i] = e_wd; p_wr[i] = e_wr; p_tag[i] = cur_tag;
        p_due[i] = ecount + ((e_mtr || e_mw) ? (i + 1) : 1);
        acc[i] = 1'b1;
      end else begin
        x_rw[i] = 1'b0;
        x_mtr[i] = 1'b0;
        x_mis[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk("stallM", i, 32'(o_stall[i]), 32'(p_due[i] > ecount + 1));
      chk("regWriteM", i, 32'(o_rwm[i]), 32'(p_rw[i]));
      chk("writeRegM", i, 32'(o_wrm[i]), 32'(p_wr[i]));
      chk("AluOutM", i, o_alum[i], p_alu[i]);
      chk("regWriteW", i, 32'(o_rww[i]), 32'(x_rw[i]));
      chk("memToRegW", i, 32'(o_mtrw[i]), 32'(x_mtr[i]));
      chk("AluOutW", i, o_aluw[i], x_alu[i]);
      chk("writeRegW", i, 32'(o_wrw[i]), 32'(x_wr[i]));
      if (x_rdk[i]) chk("ReadDataW", i, o_rdw[i], x_rd[i]);
`ifdef MEM_ALIGN_CHECK_EN
      chk("misalignW", i, 32'(o_mis[i]), 32'(x_mis[i]));
`endif
    end
  endtask

  // One clock: advance model at the edge, compare 1 time unit later, then
  // apply hand-computed expectations to tagged directed ops as they retire.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    for (int i = 0; i < N; i++) begin
      if (retired[i] && r_tag[i] == 1) begin
        chk("lit_nonmem_alu", i, o_aluw[i], 32'h0000_1234);
        chk("lit_nonmem_wreg", i, 32'(o_wrw[i]), 32'd5);
        chk("lit_nonmem_rw", i, 32'(o_rww[i]), 32'd1);
      end
      if (retired[i] && r_tag[i] == 3) begin
        chk("lit_load_data", i, o_rdw[i], 32'hDEAD_BEEF);
        chk("lit_load_mtr", i, 32'(o_mtrw[i]), 32'd1);
        chk("lit_load_stall_cycles", i, 32'(st_cnt[i]), 32'(i));
      end
      if (retired[i] && r_tag[i] == 4) begin
        chk("lit_dropped_store", i, o_rdw[i], 32'hCAFE_0020);
      end
`ifdef MEM_ALIGN_CHECK_EN
      if (retired[i] && r_tag[i] == 5) chk("lit_misalign_store", i, 32'(o_mis[i]), 32'd1);
      if (retired[i] && r_tag[i] == 6) chk("lit_misalign_load_rw", i, 32'(o_rww[i]), 32'd0);
`endif
      if (acc[i]) st_cnt[i] = 0;
      if (o_stall[i]) st_cnt[i]++;
    end
  endtask

  task automatic set_op(input logic rw, input logic mtr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] wr, input int tag);
    e_rw = rw; e_mtr = mtr; e_mw = mw; e_alu = alu; e_wd = wd; e_wr = wr;
    cur_tag = tag;
  endtask

  // Present an op until every instance has accepted it at least once.
  task automatic issue(input logic rw, input logic mtr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input int tag, input bit verbose);
    bit got [N];
    bit all_got;
    set_op(rw, mtr, mw, alu, wd, wr, tag);
    if (verbose)
      $display("txn rw=%0b mtr=%0b mw=%0b addr=%h wdata=%h wreg=%0d tag=%0d",
               rw, mtr, mw, alu, wd, wr, tag);
    for (int i = 0; i < N; i++) got[i] = 1'b0;
    all_got = 1'b0;
    for (int t = 0; t < 20 && !all_got; t++) begin
      tick();
      all_got = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) got[i] = 1'b1;
        if (!got[i]) all_got = 1'b0;
      end
    end
    if (!all_got) begin
      n_assert++;
      n_fail++;
      $display("FAIL issue_timeout actual=not_accepted expected=accepted tag=%0d", tag);
    end
  endtask

  task automatic settle();
    set_op(0, 0, 0, '0, '0, '0, 0);
    for (int t = 0; t < 4; t++) tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      st_cnt[i] = 0;
      for (int a = 0; a < DEPTH; a++) mk[i][a] = 1'b0;
    end

    // Reset for two cycles, then check the reset state literally.
    reset = 1'b1;
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      chk("rst_regWriteW", i, 32'(o_rww[i]), 32'd0);
      chk("rst_memToRegW", i, 32'(o_mtrw[i]), 32'd0);
      chk("rst_ReadDataW", i, o_rdw[i], 32'd0);
      chk("rst_AluOutW", i, o_aluw[i], 32'd0);
      chk("rst_writeRegW", i, 32'(o_wrw[i]), 32'd0);
      chk("rst_stallM", i, 32'(o_stall[i]), 32'd0);
      chk("rst_regWriteM", i, 32'(o_rwm[i]), 32'd0);
    end
    reset = 1'b0;
    settle();

    // Fill every word so later reads have known contents.
    for (int a = 0; a < DEPTH; a++)
      issue(0, 0, 1, 32'(a << 2), (a == 8) ? 32'hCAFE_0020 : $urandom, '0, 0, 1'b0);
    settle();

    // Non-memory op.
    issue(1, 0, 0, 32'h0000_1234, '0, 5'd5, 1, 1'b1);
    settle();

    // Store then load same address; next op presented during the stall.
    issue(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, '0, 2, 1'b1);
    issue(1, 1, 0, 32'h0000_0010, '0, 5'd7, 3, 1'b1);
    issue(1, 0, 0, 32'h0000_0055, '0, 5'd9, 0, 1'b1);
    settle();

    // Reset while a store to 0x20 waits; the store must be dropped.
    set_op(0, 0, 1, 32'h0000_0020, 32'h1111_1111, '0, 0);
    $display("txn store addr=00000020 wdata=11111111 then reset");
    tick();
    set_op(0, 0, 0, '0, '0, '0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    issue(1, 1, 0, 32'h0000_0020, '0, 5'd3, 4, 1'b1);
    settle();

`ifdef MEM_ALIGN_CHECK_EN
    issue(0, 0, 1, 32'h0000_0022, 32'h9999_9999, '0, 5, 1'b1);
    issue(1, 1, 0, 32'h0000_0021, '0, 5'd4, 6, 1'b1);
    issue(1, 1, 0, 32'h0000_0020, '0, 5'd3, 4, 1'b1);
    settle();
`endif

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      e_rw    = 1'($urandom_range(0, 1));
      e_mtr   = 1'($urandom_range(0, 3) == 0);
      e_mw    = 1'($urandom_range(0, 3) == 0);
      e_alu   = $urandom;
      e_wd    = $urandom;
      e_wr    = 5'($urandom);
      cur_tag = 0;
      reset   = 1'($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
